// File: rtl/regfile_write_arbiter.sv
// Register-file write arbiter: merges ALU (source A) and load-unit (source B) results onto
// a single registered write port. Each source is buffered in its own FIFO and a round-robin
// arbiter pops at most one entry per cycle. Writes to register 0 are dropped at entry.
// A pending-write query reports registers with writes still outstanding.
// Optional feature macro: WB_DIRECT_EN -- an accepted write whose FIFO is empty and which
// wins arbitration bypasses its FIFO straight into the output register.
module regfile_write_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iValidA,
  output logic                  oReadyA,
  input  logic [ADDR_WIDTH-1:0] iAddrA,
  input  logic [DATA_WIDTH-1:0] iDataA,
  input  logic                  iValidB,
  output logic                  oReadyB,
  input  logic [ADDR_WIDTH-1:0] iAddrB,
  input  logic [DATA_WIDTH-1:0] iDataB,
  output logic                  oEnWrite,
  output logic [ADDR_WIDTH-1:0] oAddrWrite,
  output logic [DATA_WIDTH-1:0] oDataWrite,
  input  logic [ADDR_WIDTH-1:0] iAddrQuery0,
  input  logic [ADDR_WIDTH-1:0] iAddrQuery1,
  output logic                  oPending0,
  output logic                  oPending1
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [0:0] {StLastA, StLastB} arb_state_e;

  // Index 0 is source A, index 1 is source B throughout.
  logic [1:0]            valid_in;
  logic [ADDR_WIDTH-1:0] addr_in [2];
  logic [DATA_WIDTH-1:0] data_in [2];
  logic [ADDR_WIDTH-1:0] query   [2];

  logic [ADDR_WIDTH-1:0] mem_addr_q [2][FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_q [2][FIFO_DEPTH];
  logic [PtrW-1:0]       wr_ptr_q [2];
  logic [PtrW-1:0]       wr_ptr_d [2];
  logic [PtrW-1:0]       rd_ptr_q [2];
  logic [PtrW-1:0]       rd_ptr_d [2];
  logic [CntW-1:0]       count_q  [2];
  logic [CntW-1:0]       count_d  [2];

  arb_state_e state_q, state_d;

  logic                  en_q, en_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  logic [1:0] full, not_empty, ready, push_req, direct_cand, req, grant, pop, direct, push;
  logic [1:0] hit;

  assign valid_in   = {iValidB, iValidA};
  assign addr_in[0] = iAddrA;
  assign addr_in[1] = iAddrB;
  assign data_in[0] = iDataA;
  assign data_in[1] = iDataB;
  assign query[0]   = iAddrQuery0;
  assign query[1]   = iAddrQuery1;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    if (ptr == PtrW'(FIFO_DEPTH - 1)) return '0;
    return ptr + PtrW'(1);
  endfunction

  // Handshake: ready is purely from registered occupancy; forced low while in reset.
  always_comb begin
    full      = '0;
    not_empty = '0;
    ready     = '0;
    push_req  = '0;
    for (int unsigned s = 0; s < 2; s++) begin
      full[s]      = (count_q[s] == CntW'(FIFO_DEPTH));
      not_empty[s] = (count_q[s] != '0);
      ready[s]     = !iRst && !full[s];
      // Register-0 writes complete the handshake but are never stored.
      push_req[s]  = valid_in[s] && ready[s] && (addr_in[s] != '0);
    end
  end

  assign oReadyA = ready[0];
  assign oReadyB = ready[1];

  // Arbiter next state: round-robin between requesting sources, favouring the one not
  // granted last.
  always_comb begin
    direct_cand = '0;
`ifdef WB_DIRECT_EN
    direct_cand = push_req & ~not_empty;
`endif
    req     = not_empty | direct_cand;
    grant   = '0;
    state_d = state_q;
    if (req[0] && (!req[1] || state_q == StLastB)) begin
      grant[0] = 1'b1;
      state_d  = StLastA;
    end else if (req[1]) begin
      grant[1] = 1'b1;
      state_d  = StLastB;
    end
    pop    = grant & not_empty;
    // A grant to an empty FIFO can only come from a bypass candidate.
    direct = grant & ~not_empty;
    push   = push_req & ~direct;
  end

  // Arbiter state register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= StLastB;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointer and occupancy next state.
  always_comb begin
    for (int unsigned s = 0; s < 2; s++) begin
      wr_ptr_d[s] = push[s] ? ptr_inc(wr_ptr_q[s]) : wr_ptr_q[s];
      rd_ptr_d[s] = pop[s]  ? ptr_inc(rd_ptr_q[s]) : rd_ptr_q[s];
      count_d[s]  = count_q[s] + CntW'(push[s]) - CntW'(pop[s]);
    end
  end

  // FIFO pointer and occupancy registers.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
        count_q[s]  <= '0;
      end
    end else begin
      for (int unsigned s = 0; s < 2; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
        count_q[s]  <= count_d[s];
      end
    end
  end

  // FIFO storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge iClk) begin
    for (int unsigned s = 0; s < 2; s++) begin
      if (push[s]) begin
        mem_addr_q[s][wr_ptr_q[s]] <= addr_in[s];
        mem_data_q[s][wr_ptr_q[s]] <= data_in[s];
      end
    end
  end

  // Output register next state: load the granted entry, otherwise hold addr/data.
  always_comb begin
    en_d   = |grant;
    addr_d = addr_q;
    data_d = data_q;
    for (int unsigned s = 0; s < 2; s++) begin
      if (grant[s]) begin
        if (pop[s]) begin
          addr_d = mem_addr_q[s][rd_ptr_q[s]];
          data_d = mem_data_q[s][rd_ptr_q[s]];
        end else begin
          addr_d = addr_in[s];
          data_d = data_in[s];
        end
      end
    end
  end

  // Output register.
  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      en_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign oEnWrite   = en_q;
  assign oAddrWrite = addr_q;
  assign oDataWrite = data_q;

  // Pending query: match against occupied FIFO slots and the live output register.
  always_comb begin
    logic [PtrW-1:0] occ;
    occ = '0;
    hit = '0;
    for (int unsigned n = 0; n < 2; n++) begin
      for (int unsigned s = 0; s < 2; s++) begin
        for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
          // Slot distance from the read pointer; occupied if below the count.
          occ = PtrW'(i) - rd_ptr_q[s];
          if ((CntW'(occ) < count_q[s]) && (mem_addr_q[s][i] == query[n])) begin
            hit[n] = 1'b1;
          end
        end
      end
      if (en_q && (addr_q == query[n])) begin
        hit[n] = 1'b1;
      end
      if (query[n] == '0) begin
        hit[n] = 1'b0;
      end
    end
  end

  assign oPending0 = hit[0];
  assign oPending1 = hit[1];

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: queue-based reference model predicts each register-file
// write and the cycle it should appear; a monitor pops and compares whenever a write is due.
module tb_regfile_write_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;

  logic          iClk = 1'b0;
  logic          iRst;
  logic          iValidA, iValidB;
  logic          oReadyA, oReadyB;
  logic [AW-1:0] iAddrA, iAddrB;
  logic [DW-1:0] iDataA, iDataB;
  logic          oEnWrite;
  logic [AW-1:0] oAddrWrite;
  logic [DW-1:0] oDataWrite;
  logic [AW-1:0] iAddrQuery0, iAddrQuery1;
  logic          oPending0, oPending1;

  regfile_write_arbiter #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .iClk        (iClk),
    .iRst        (iRst),
    .iValidA     (iValidA),
    .oReadyA     (oReadyA),
    .iAddrA      (iAddrA),
    .iDataA      (iDataA),
    .iValidB     (iValidB),
    .oReadyB     (oReadyB),
    .iAddrB      (iAddrB),
    .iDataB      (iDataB),
    .oEnWrite    (oEnWrite),
    .oAddrWrite  (oAddrWrite),
    .oDataWrite  (oDataWrite),
    .iAddrQuery0 (iAddrQuery0),
    .iAddrQuery1 (iAddrQuery1),
    .oPending0   (oPending0),
    .oPending1   (oPending1)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ent_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [31:0]   cyc;
  } exp_t;

  ent_t          qa[$];
  ent_t          qb[$];
  exp_t          exp_q[$];
  bit            last_a;   // model: last grant went to A
  bit            m_en;     // model: output register live
  logic [AW-1:0] m_addr;
  int unsigned   cyc = 0;
  int            vectors = 0;
  int            errors = 0;

  always #5 iClk = ~iClk;

  always @(posedge iClk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every negedge, a write must be present exactly when the head entry is due.
  always @(negedge iClk) begin
    bit   due;
    exp_t e;
    due = (exp_q.size() > 0) && (exp_q[0].cyc <= cyc);
    check("write enable", {63'd0, oEnWrite}, {63'd0, due});
    if (due) begin
      e = exp_q.pop_front();
      if (oEnWrite === 1'b1) begin
        check("write addr", {59'd0, oAddrWrite}, {59'd0, e.addr});
        check("write data", {32'd0, oDataWrite}, {32'd0, e.data});
      end
    end
  end

  function automatic bit model_pending(input logic [AW-1:0] q);
    if (q == '0) return 1'b0;
    if (m_en && m_addr == q) return 1'b1;
    foreach (qa[i]) if (qa[i].addr == q) return 1'b1;
    foreach (qb[i]) if (qb[i].addr == q) return 1'b1;
    return 1'b0;
  endfunction

  // One clock: drive inputs, check ready/pending, advance the model over the next edge.
  task automatic step(input bit va, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                      input bit vb, input logic [AW-1:0] ab, input logic [DW-1:0] db,
                      input logic [AW-1:0] q0, input logic [AW-1:0] q1,
                      output bit acc_a, output bit acc_b);
    bit   ra, rb, push_a, push_b, av_a, av_b, cand_a, cand_b, req_a, req_b, pick_a, pick_b;
    ent_t na, nb, w;
    iValidA = va; iAddrA = aa; iDataA = da;
    iValidB = vb; iAddrB = ab; iDataB = db;
    iAddrQuery0 = q0; iAddrQuery1 = q1;
    #1;
    ra = (qa.size() < DEPTH);
    rb = (qb.size() < DEPTH);
    check("readyA", {63'd0, oReadyA}, {63'd0, ra});
    check("readyB", {63'd0, oReadyB}, {63'd0, rb});
    check("pending0", {63'd0, oPending0}, {63'd0, model_pending(q0)});
    check("pending1", {63'd0, oPending1}, {63'd0, model_pending(q1)});
    acc_a  = va && ra;
    acc_b  = vb && rb;
    push_a = acc_a && (aa != '0);
    push_b = acc_b && (ab != '0);
    na = '{addr: aa, data: da};
    nb = '{addr: ab, data: db};
    av_a = (qa.size() > 0);
    av_b = (qb.size() > 0);
    cand_a = 1'b0;
    cand_b = 1'b0;
`ifdef WB_DIRECT_EN
    cand_a = push_a && !av_a;
    cand_b = push_b && !av_b;
`endif
    req_a  = av_a || cand_a;
    req_b  = av_b || cand_b;
    pick_a = req_a && (!req_b || !last_a);
    pick_b = req_b && !pick_a;
    w      = '0;
    if (pick_a) begin
      if (av_a) w = qa.pop_front();
      else begin w = na; push_a = 1'b0; end
      last_a = 1'b1;
    end
    if (pick_b) begin
      if (av_b) w = qb.pop_front();
      else begin w = nb; push_b = 1'b0; end
      last_a = 1'b0;
    end
    if (push_a) qa.push_back(na);
    if (push_b) qb.push_back(nb);
    m_en = pick_a || pick_b;
    if (m_en) begin
      m_addr = w.addr;
      exp_q.push_back('{addr: w.addr, data: w.data, cyc: cyc + 1});
    end
    @(negedge iClk);
    #1;
  endtask

  task automatic idle(input int n, input logic [AW-1:0] q0);
    bit a, b;
    for (int i = 0; i < n; i++) step(0, '0, '0, 0, '0, '0, q0, 5'd0, a, b);
  endtask

  task automatic model_flush();
    qa.delete();
    qb.delete();
    exp_q.delete();
    last_a = 1'b0;
    m_en   = 1'b0;
    m_addr = '0;
  endtask

  initial begin
    bit            a, b, hold_a, hold_b;
    int            n, nb_cnt, guard;
    logic [AW-1:0] ra_addr, rb_addr;
    logic [DW-1:0] ra_data, rb_data;
    bit            rva, rvb;

    iRst = 1'b1;
    iValidA = 0; iValidB = 0; iAddrA = '0; iAddrB = '0; iDataA = '0; iDataB = '0;
    iAddrQuery0 = 5'd3; iAddrQuery1 = '0;
    model_flush();
    #1;
    check("reset en", {63'd0, oEnWrite}, 64'd0);
    check("reset addr", {59'd0, oAddrWrite}, 64'd0);
    check("reset data", {32'd0, oDataWrite}, 64'd0);
    check("reset readyA", {63'd0, oReadyA}, 64'd0);
    check("reset readyB", {63'd0, oReadyB}, 64'd0);
    @(negedge iClk); @(negedge iClk);
    #1;
    iRst = 1'b0;

    // Single write to r3, then query r3 while it drains.
    step(1, 5'd3, 32'hDEAD_BEEF, 0, '0, '0, 5'd3, 5'd0, a, b);
    idle(4, 5'd3);

    // Register-0 write from B: handshake only.
    step(0, '0, '0, 1, 5'd0, 32'h1234_5678, 5'd0, 5'd0, a, b);
    check("r0 accepted", {63'd0, b}, 64'd1);
    idle(3, 5'd0);

    // B-only write so A is favoured next, then simultaneous streams r1..r3 / r4..r6.
    step(0, '0, '0, 1, 5'd7, 32'h0000_0007, 5'd7, 5'd0, a, b);
    idle(3, 5'd7);
    for (int i = 0; i < 3; i++)
      step(1, 5'(1 + i), 32'hA0 + i, 1, 5'(4 + i), 32'hB0 + i, 5'(1 + i), 5'(4 + i), a, b);
    idle(8, 5'd2);

    // A holds valid for 10 entries while B floods; A fills and must stall at count 4.
    n = 0; nb_cnt = 0; guard = 0;
    while (n < 10 && guard < 200) begin
      step(1, 5'(1 + n), 32'hAA00_0000 + n, 1, 5'(16 + nb_cnt % 8), 32'hBB00_0000 + nb_cnt,
           5'(1 + n), 5'(16 + nb_cnt % 8), a, b);
      if (a) n++;
      if (b) nb_cnt++;
      guard++;
    end
    check("fill progress", 64'(n), 64'd10);
    idle(20, 5'd1);

    // Async reset mid-stream with entries pending.
    for (int i = 0; i < 3; i++)
      step(1, 5'(9 + i), 32'hC0 + i, 1, 5'(20 + i), 32'hD0 + i, 5'd9, 5'd20, a, b);
    #2;
    iRst = 1'b1;
    #1;
    check("arst en", {63'd0, oEnWrite}, 64'd0);
    check("arst readyA", {63'd0, oReadyA}, 64'd0);
    check("arst readyB", {63'd0, oReadyB}, 64'd0);
    check("arst pending0", {63'd0, oPending0}, 64'd0);
    check("arst pending1", {63'd0, oPending1}, 64'd0);
    model_flush();
    @(negedge iClk); @(negedge iClk);
    #1;
    iRst = 1'b0;
    idle(2, 5'd9);
    // First grant after reset must go to A.
    step(1, 5'd12, 32'hE0, 1, 5'd24, 32'hF0, 5'd12, 5'd24, a, b);
    idle(4, 5'd24);

    // Randomized traffic; sources hold addr/data while stalled. A uses r0..r15, B r16..r31.
    hold_a = 0; hold_b = 0;
    ra_addr = '0; rb_addr = '0; ra_data = '0; rb_data = '0; rva = 0; rvb = 0;
    for (int i = 0; i < 400; i++) begin
      if (!hold_a) begin
        rva     = ($urandom_range(0, 99) < 60);
        ra_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 15));
        ra_data = $urandom;
      end
      if (!hold_b) begin
        rvb     = ($urandom_range(0, 99) < 60);
        rb_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(16, 31));
        rb_data = $urandom;
      end
      step(rva, ra_addr, ra_data, rvb, rb_addr, rb_data,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), a, b);
      hold_a = rva && !a;
      hold_b = rvb && !b;
    end
    idle(20, 5'd0);
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
